// File: rtl/reg_rename_file_pkg.sv
// Shared core constants and types for the rename register file, ROB,
// reservation stations and load/store buffer.
package reg_rename_file_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int Q_WIDTH        = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_COUNT      = 2 ** REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [Q_WIDTH-1:0]        rob_tag_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  // The ROB never allocates tag 0, so it doubles as "value is ready".
  localparam rob_tag_t NO_TAG = '0;

  typedef struct packed {
    logic     busy;
    rob_tag_t q;
    data_t    v;
  } operand_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// Issue, operand-read and commit signals between the issue/ROB logic (master)
// and the rename register file (slave).
interface reg_rename_file_if;
  import reg_rename_file_pkg::*;

  logic      rdy_in;
  logic      has_issue;
  reg_addr_t issue_rd;
  rob_tag_t  issue_rob_pos;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic      rs1_busy;
  logic      rs2_busy;
  rob_tag_t  rs1_Q;
  rob_tag_t  rs2_Q;
  data_t     rs1_V;
  data_t     rs2_V;

  logic      commit_modify_regfile;
  reg_addr_t commit_reg_addr;
  rob_tag_t  Commit_Q;
  data_t     Commit_V;

  logic      control_hazard;

  modport master (
    output rdy_in, has_issue, issue_rd, issue_rob_pos,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy, rs1_Q, rs2_Q, rs1_V, rs2_V,
    output commit_modify_regfile, commit_reg_addr, Commit_Q, Commit_V,
    output control_hazard
  );

  modport slave (
    input  rdy_in, has_issue, issue_rd, issue_rob_pos,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy, rs1_Q, rs2_Q, rs1_V, rs2_V,
    input  commit_modify_regfile, commit_reg_addr, Commit_Q, Commit_V,
    input  control_hazard
  );

endinterface

// File: rtl/reg_rename_file_read_port.sv
// One operand read port: turns the selected register's state into a
// value-or-tag pair, with x0 forced to zero and a bypass from the commit bus.
module regfile_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_addr_t addr,
  input  data_t     reg_value,
  input  logic      reg_busy,
  input  rob_tag_t  reg_tag,
  input  logic      commit_modify_regfile,
  input  reg_addr_t commit_reg_addr,
  input  rob_tag_t  commit_q,
  input  data_t     commit_v,
  output operand_t  operand
);

  logic commit_bypass;

  // The bypass only fires when the retiring entry is the register's latest
  // producer; an older producer retiring leaves the operand pending.
  assign commit_bypass = commit_modify_regfile
                      && (addr == commit_reg_addr)
                      && reg_busy
                      && (reg_tag == commit_q);

  always_comb begin
    operand.busy = 1'b0;
    operand.q    = NO_TAG;
    operand.v    = reg_value;
    if (is_x0(addr)) begin
      operand.v = '0;
    end else if (commit_bypass) begin
      operand.v = commit_v;
    end else if (reg_busy) begin
      operand.busy = 1'b1;
      operand.q    = reg_tag;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags: renames at
// issue, retires values from the ROB head, drops all renames on a flush.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input logic               clk_in,
  input logic               rst_in,
  reg_rename_file_if.slave  bus
);

  data_t    value_q [REG_COUNT];
  logic     busy_q  [REG_COUNT];
  rob_tag_t tag_q   [REG_COUNT];

  logic issue_fire;
  logic commit_fire;
  logic flush_fire;

  // A flush cancels the instruction issuing alongside it.
  assign issue_fire  = bus.has_issue && bus.rdy_in && !bus.control_hazard
                    && !is_x0(bus.issue_rd);
  assign commit_fire = bus.commit_modify_regfile && bus.rdy_in
                    && !is_x0(bus.commit_reg_addr);
  assign flush_fire  = bus.control_hazard && bus.rdy_in;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign value_q[gi] = '0;
        assign busy_q[gi]  = 1'b0;
        assign tag_q[gi]   = NO_TAG;
      end else begin : g_state
        localparam reg_addr_t IDX = reg_addr_t'(gi);

        data_t    value_reg;
        logic     busy_reg;
        rob_tag_t tag_reg;
        logic     issue_hit;
        logic     commit_hit;

        assign issue_hit  = issue_fire  && (bus.issue_rd == IDX);
        assign commit_hit = commit_fire && (bus.commit_reg_addr == IDX);

        // Committed values always land; busy/tag priority is flush, then a
        // new rename, then retirement of the current producer.
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) begin
            value_reg <= '0;
            busy_reg  <= 1'b0;
            tag_reg   <= NO_TAG;
          end else begin
            if (commit_hit) begin
              value_reg <= bus.Commit_V;
            end
            if (flush_fire) begin
              busy_reg <= 1'b0;
              tag_reg  <= NO_TAG;
            end else if (issue_hit) begin
              busy_reg <= 1'b1;
              tag_reg  <= bus.issue_rob_pos;
            end else if (commit_hit && (tag_reg == bus.Commit_Q)) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign value_q[gi] = value_reg;
        assign busy_q[gi]  = busy_reg;
        assign tag_q[gi]   = tag_reg;
      end
    end
  endgenerate

  operand_t rs1_operand;
  operand_t rs2_operand;

  regfile_read_port u_rs1_port (
    .addr                  (bus.rs1_addr),
    .reg_value             (value_q[bus.rs1_addr]),
    .reg_busy              (busy_q[bus.rs1_addr]),
    .reg_tag               (tag_q[bus.rs1_addr]),
    .commit_modify_regfile (bus.commit_modify_regfile),
    .commit_reg_addr       (bus.commit_reg_addr),
    .commit_q              (bus.Commit_Q),
    .commit_v              (bus.Commit_V),
    .operand               (rs1_operand)
  );

  regfile_read_port u_rs2_port (
    .addr                  (bus.rs2_addr),
    .reg_value             (value_q[bus.rs2_addr]),
    .reg_busy              (busy_q[bus.rs2_addr]),
    .reg_tag               (tag_q[bus.rs2_addr]),
    .commit_modify_regfile (bus.commit_modify_regfile),
    .commit_reg_addr       (bus.commit_reg_addr),
    .commit_q              (bus.Commit_Q),
    .commit_v              (bus.Commit_V),
    .operand               (rs2_operand)
  );

  assign bus.rs1_busy = rs1_operand.busy;
  assign bus.rs1_Q    = rs1_operand.q;
  assign bus.rs1_V    = rs1_operand.v;
  assign bus.rs2_busy = rs2_operand.busy;
  assign bus.rs2_Q    = rs2_operand.q;
  assign bus.rs2_V    = rs2_operand.v;

endmodule
